pooling_backward_pipe: RTL and testbench

POOLING_BACKWARD_PIPE -- requirements
Module: pooling_backward_pipe

---
 rtl/pooling_backward_if.sv | 31 +++
 rtl/pooling_backward_pipe.sv | 161 ++++++++++++++++
 tb/tb_pooling_backward_pipe.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pooling_backward_if.sv
// Window bus for pooling_backward_pipe: input window + error term in, back-propagated window out.
// Handshake: a window moves on a rising clk edge where valid and ready are both 1; the sender holds
// valid and its payload steady until that edge, and valid never waits on ready.
interface pooling_backward_if #(
  parameter int K_W   = 3,
  parameter int K_H   = 3,
  parameter int CNT_W = 16
);
  localparam int K_SIZE = K_W * K_H;

  logic                     in_valid;
  logic                     in_ready;
  logic [7:0]               max_flt_idx;
  logic [K_SIZE-1:0][31:0]  data_vect_in;
  logic [31:0]              error_term;
  logic                     out_valid;
  logic                     out_ready;
  logic [K_SIZE-1:0][31:0]  data_vect_out;
  logic [CNT_W-1:0]         win_count;
  logic                     idx_err;

  modport master (
    output in_valid, max_flt_idx, data_vect_in, error_term, out_ready,
    input  in_ready, out_valid, data_vect_out, win_count, idx_err
  );

  modport slave (
    input  in_valid, max_flt_idx, data_vect_in, error_term, out_ready,
    output in_ready, out_valid, data_vect_out, win_count, idx_err
  );
endinterface

// File: rtl/pooling_backward_pipe.sv
// Max-pooling backward pass: routes error_term * max element into the max slot of the window.
// Macro POOL_BWD_ZERO_FILL_EN zeroes non-max elements; undefined, they pass through delayed.
module float_mult #(
  parameter int LAT = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  logic [31:0] res;
  logic        sgn;
  logic [47:0] prod;
  logic [22:0] mant;
  logic        guard, sticky;
  logic [23:0] mr;
  logic [9:0]  e;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [LAT-1:0][31:0] pipe;

  // Round-to-nearest-even on normals; subnormal inputs and underflow flush to signed zero.
  always_comb begin
    sgn    = a[31] ^ b[31];
    a_nan  = (&a[30:23]) && (|a[22:0]);
    b_nan  = (&b[30:23]) && (|b[22:0]);
    a_inf  = (&a[30:23]) && !(|a[22:0]);
    b_inf  = (&b[30:23]) && !(|b[22:0]);
    a_zero = !(|a[30:23]);
    b_zero = !(|b[30:23]);
    prod   = {24'b0, 1'b1, a[22:0]} * {24'b0, 1'b1, b[22:0]};
    if (prod[47]) begin
      mant   = prod[46:24];
      guard  = prod[23];
      sticky = |prod[22:0];
      e      = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd126;
    end else begin
      mant   = prod[45:23];
      guard  = prod[22];
      sticky = |prod[21:0];
      e      = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
    end
    mr = {1'b0, mant} + {23'b0, guard & (sticky | mant[0])};
    if (mr[23]) e = e + 10'd1;
    if (a_nan || b_nan)                   res = 32'h7FC0_0000;
    else if (a_inf || b_inf)              res = (a_zero || b_zero) ? 32'h7FC0_0000 : {sgn, 8'hFF, 23'b0};
    else if (a_zero || b_zero)            res = {sgn, 31'b0};
    else if ($signed(e) >= $signed(10'd255)) res = {sgn, 8'hFF, 23'b0};
    else if ($signed(e) <= $signed(10'd0))   res = {sgn, 31'b0};
    else                                  res = {sgn, e[7:0], mr[22:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe <= '0;
    end else if (clk_en) begin
      pipe[0] <= res;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign y = pipe[LAT-1];
endmodule

module pooling_backward_pipe #(
  parameter int K_W      = 3,
  parameter int K_H      = 3,
  parameter int MULT_LAT = 5,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  pooling_backward_if.slave bus
);
  localparam int K_SIZE = K_W * K_H;
  typedef logic [K_SIZE-1:0][31:0] vec_t;

  logic                adv;
  logic                has_max;
  logic [31:0]         max_elem;
  logic [31:0]         prod;
  vec_t                d_in;
  vec_t                out_vec;
  logic [MULT_LAT-1:0] v_q;
  logic [MULT_LAT-1:0] hm_q;
  vec_t                d_q   [MULT_LAT];
  logic [7:0]          idx_q [MULT_LAT];
  logic                idx_err_q;
  logic [CNT_W-1:0]    cnt_q;

  // One enable for everything: the pipe moves unless a finished window is stuck at the output.
  assign adv          = !v_q[MULT_LAT-1] || bus.out_ready;
  assign bus.in_ready = adv;
  assign has_max      = int'(bus.max_flt_idx) < K_SIZE;

  always_comb begin
    max_elem = '0;
    for (int i = 0; i < K_SIZE; i++)
      if (int'(bus.max_flt_idx) == i) max_elem = bus.data_vect_in[i];
`ifdef POOL_BWD_ZERO_FILL_EN
    d_in = '0;
`else
    d_in = bus.data_vect_in;
`endif
  end

  float_mult #(.LAT(MULT_LAT)) u_mult (
    .clk    (clk),
    .rst    (reset),
    .clk_en (adv),
    .a      (max_elem),
    .b      (bus.error_term),
    .y      (prod)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q  <= '0;
      hm_q <= '0;
      for (int i = 0; i < MULT_LAT; i++) begin
        d_q[i]   <= '0;
        idx_q[i] <= '0;
      end
    end else if (adv) begin
      v_q[0]   <= bus.in_valid;
      hm_q[0]  <= has_max;
      d_q[0]   <= d_in;
      idx_q[0] <= bus.max_flt_idx;
      for (int i = 1; i < MULT_LAT; i++) begin
        v_q[i]   <= v_q[i-1];
        hm_q[i]  <= hm_q[i-1];
        d_q[i]   <= d_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  // The product lands in the max slot only at the output, so the shift stages carry plain data.
  always_comb begin
    out_vec = d_q[MULT_LAT-1];
    if (hm_q[MULT_LAT-1])
      for (int i = 0; i < K_SIZE; i++)
        if (int'(idx_q[MULT_LAT-1]) == i) out_vec[i] = prod;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_err_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (bus.in_valid && adv && !has_max) idx_err_q <= 1'b1;
      if (v_q[MULT_LAT-1] && bus.out_ready) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.out_valid     = v_q[MULT_LAT-1];
  assign bus.data_vect_out = out_vec;
  assign bus.win_count     = cnt_q;
  assign bus.idx_err       = idx_err_q;
endmodule

// File: tb/tb_pooling_backward_pipe.sv
// Bench for pooling_backward_pipe: product table, latency, throughput, stall, bad index, mid-flight reset.
// Honours POOL_BWD_ZERO_FILL_EN when building expected windows.
module tb_pooling_backward_pipe;
  localparam int K_W   = 3;
  localparam int K_H   = 3;
  localparam int K     = K_W * K_H;
  localparam int LAT   = 5;
  localparam int CNT_W = 16;
  localparam int OUT_W = K * 32;
  localparam int NTBL  = 10;

  typedef logic [K-1:0][31:0] vec_t;
  typedef struct {
    logic [7:0]  idx;
    logic [31:0] mx;
    logic [31:0] err;
    logic [31:0] prod;
  } vec_rec_t;

  logic clk = 1'b0;
  logic reset;
  pooling_backward_if #(.K_W(K_W), .K_H(K_H), .CNT_W(CNT_W)) bus ();

  pooling_backward_pipe #(.K_W(K_W), .K_H(K_H), .MULT_LAT(LAT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [OUT_W-1:0] exp_q[$];
  logic [CNT_W-1:0] exp_cnt;
  int               n_total = 0;
  int               n_pass  = 0;
  vec_rec_t         tbl [NTBL];

  task automatic chk(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t model(input logic [7:0] idx, input vec_t d, input logic [31:0] prod);
    vec_t r;
    for (int i = 0; i < K; i++) begin
`ifdef POOL_BWD_ZERO_FILL_EN
      r[i] = 32'h0;
`else
      r[i] = d[i];
`endif
      if (int'(idx) == i) r[i] = prod;
    end
    return r;
  endfunction

  function automatic vec_t rand_vec(input logic [7:0] idx, input logic [31:0] mx);
    vec_t d;
    for (int i = 0; i < K; i++) d[i] = $urandom;
    if (int'(idx) < K) d[idx] = mx;
    return d;
  endfunction

  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", OUT_W'(bus.out_valid), OUT_W'(0));
      end else begin
        chk("win_count_at_xfer", OUT_W'(bus.win_count), OUT_W'(exp_cnt));
        chk("data_out", bus.data_vect_out, exp_q.pop_front());
        exp_cnt = exp_cnt + 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [7:0] idx, input vec_t d, input logic [31:0] err,
                      input logic [31:0] prod, output int waits);
    bus.in_valid     = 1'b1;
    bus.max_flt_idx  = idx;
    bus.data_vect_in = d;
    bus.error_term   = err;
    waits = 0;
    while (1) begin
      @(negedge clk);
      if (bus.in_ready) break;
      waits++;
      if (waits > 200) break;
    end
    if (bus.in_ready) exp_q.push_back(model(idx, d, prod));
    else chk("accept_timeout", OUT_W'(bus.in_ready), OUT_W'(1));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    chk("drain_queue_empty", OUT_W'(exp_q.size()), OUT_W'(0));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int   waits, lat, run, sum_waits, w;
    vec_t d;

    tbl[0] = '{8'd4, 32'h4000_0000, 32'h3F00_0000, 32'h3F80_0000};
    tbl[1] = '{8'd0, 32'h4040_0000, 32'h4000_0000, 32'h40C0_0000};
    tbl[2] = '{8'd8, 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000};
    tbl[3] = '{8'd2, 32'hC000_0000, 32'h3E80_0000, 32'hBF00_0000};
    tbl[4] = '{8'd5, 32'h0000_0000, 32'h4000_0000, 32'h0000_0000};
    tbl[5] = '{8'd7, 32'h7F80_0000, 32'h4000_0000, 32'h7F80_0000};
    tbl[6] = '{8'd1, 32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000};
    tbl[7] = '{8'd3, 32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000};
    tbl[8] = '{8'd6, 32'h3F80_0000, 32'h3FAA_AAAB, 32'h3FAA_AAAB};
    tbl[9] = '{8'd4, 32'hC040_0000, 32'hC000_0000, 32'h40C0_0000};

    reset = 1'b1;
    exp_cnt = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.max_flt_idx = '0;
    bus.data_vect_in = '0;
    bus.error_term = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", OUT_W'(bus.out_valid), OUT_W'(0));
    chk("reset_data_out", bus.data_vect_out, '0);
    chk("reset_win_count", OUT_W'(bus.win_count), OUT_W'(0));
    chk("reset_idx_err", OUT_W'(bus.idx_err), OUT_W'(0));
    chk("reset_in_ready", OUT_W'(bus.in_ready), OUT_W'(1));
    reset = 1'b0;

    // Single window straight out of reset: first-edge accept and exact latency.
    d = rand_vec(8'd4, 32'h4000_0000);
    send(8'd4, d, 32'h3F00_0000, 32'h3F80_0000, waits);
    chk("first_accept_waits", OUT_W'(waits), OUT_W'(0));
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", OUT_W'(lat), OUT_W'(LAT));
    chk("latency_elem4", OUT_W'(bus.data_vect_out[4]), OUT_W'(32'h3F80_0000));
    repeat (3) @(posedge clk);
    #1;
    chk("win_count_one", OUT_W'(bus.win_count), OUT_W'(1));

    // All-ones window, max at 0: non-max handling.
    for (int i = 0; i < K; i++) d[i] = 32'h3F80_0000;
    send(8'd0, d, 32'h3F80_0000, 32'h3F80_0000, waits);
    w = 0;
    while (!bus.out_valid && w < 40) begin
      @(posedge clk); #1;
      w++;
    end
`ifdef POOL_BWD_ZERO_FILL_EN
    chk("nonmax_elem8", OUT_W'(bus.data_vect_out[8]), OUT_W'(32'h0));
`else
    chk("nonmax_elem8", OUT_W'(bus.data_vect_out[8]), OUT_W'(32'h3F80_0000));
`endif
    drain();

    // Product table, back to back.
    for (int j = 0; j < NTBL; j++) begin
      d = rand_vec(tbl[j].idx, tbl[j].mx);
      send(tbl[j].idx, d, tbl[j].err, tbl[j].prod, waits);
    end
    drain();

    // 20 back-to-back windows: no input stalls and an unbroken output run.
    sum_waits = 0;
    run = 0;
    fork
      begin
        for (int j = 0; j < 20; j++) begin
          int wt;
          int p;
          p = int'($urandom_range(0, NTBL - 1));
          d = rand_vec(8'($urandom_range(0, K - 1)), 32'h0);
          d = rand_vec(tbl[p].idx, tbl[p].mx);
          send(tbl[p].idx, d, tbl[p].err, tbl[p].prod, wt);
          sum_waits += wt;
        end
      end
      begin
        int wv;
        wv = 0;
        while (!bus.out_valid && wv < 100) begin
          @(negedge clk);
          wv++;
        end
        while (bus.out_valid && run < 100) begin
          run++;
          @(negedge clk);
        end
      end
    join
    chk("b2b_input_waits", OUT_W'(sum_waits), OUT_W'(0));
    chk("b2b_output_run", OUT_W'(run), OUT_W'(20));
    drain();
    chk("win_count_after_b2b", OUT_W'(bus.win_count), OUT_W'(32));

    // Fill the pipe with out_ready low, hold 10 cycles, then release.
    bus.out_ready = 1'b0;
    for (int j = 0; j < LAT; j++) begin
      d = rand_vec(tbl[j].idx, tbl[j].mx);
      send(tbl[j].idx, d, tbl[j].err, tbl[j].prod, waits);
      chk("fill_accept_waits", OUT_W'(waits), OUT_W'(0));
    end
    for (int c = 0; c < 10; c++) begin
      chk("stall_in_ready", OUT_W'(bus.in_ready), OUT_W'(0));
      chk("stall_out_valid", OUT_W'(bus.out_valid), OUT_W'(1));
      chk("stall_data_hold", bus.data_vect_out, exp_q[0]);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    drain();

    // Out-of-range index: sticky error, nothing multiplied.
    chk("idx_err_before", OUT_W'(bus.idx_err), OUT_W'(0));
    d = rand_vec(8'd12, 32'h0);
    send(8'd12, d, 32'h4000_0000, 32'h0, waits);
    chk("idx_err_set", OUT_W'(bus.idx_err), OUT_W'(1));
    for (int j = 0; j < 2; j++) begin
      d = rand_vec(tbl[j].idx, tbl[j].mx);
      send(tbl[j].idx, d, tbl[j].err, tbl[j].prod, waits);
    end
    drain();
    chk("idx_err_sticky", OUT_W'(bus.idx_err), OUT_W'(1));

    // Three windows in flight, async reset pulse between edges.
    bus.out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      d = rand_vec(tbl[j].idx, tbl[j].mx);
      send(tbl[j].idx, d, tbl[j].err, tbl[j].prod, waits);
    end
    w = 0;
    while (!bus.out_valid && w < 40) begin
      @(posedge clk); #1;
      w++;
    end
    chk("pre_reset_out_valid", OUT_W'(bus.out_valid), OUT_W'(1));
    #2;
    reset = 1'b1;
    exp_q.delete();
    exp_cnt = '0;
    #1;
    chk("midreset_out_valid", OUT_W'(bus.out_valid), OUT_W'(0));
    chk("midreset_win_count", OUT_W'(bus.win_count), OUT_W'(0));
    chk("midreset_data_out", bus.data_vect_out, '0);
    chk("midreset_idx_err", OUT_W'(bus.idx_err), OUT_W'(0));
    chk("midreset_in_ready", OUT_W'(bus.in_ready), OUT_W'(1));
    @(posedge clk); #1;
    reset = 1'b0;
    bus.out_ready = 1'b1;
    d = rand_vec(tbl[3].idx, tbl[3].mx);
    send(tbl[3].idx, d, tbl[3].err, tbl[3].prod, waits);
    chk("post_reset_accept_waits", OUT_W'(waits), OUT_W'(0));
    repeat (3 * LAT) @(posedge clk);
    #1;
    drain();
    chk("post_reset_win_count", OUT_W'(bus.win_count), OUT_W'(1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
